fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/eka_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eka_pkg.sv
// Shared fetch-side definitions: machine width, reset/NOP constants, the
// instruction alignment mask and the {pc, inst} buffer entry layout.
package eka_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_ALIGN       = 32'hFFFF_FFFC;

  // One instruction buffer entry as seen by decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & INST_ALIGN;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with synchronous flush, used for the instruction
// buffer and for the PC tag queue.
//   clk, rst_n      clock, async active-low reset
//   flush           empty the queue (takes priority over push)
//   push, push_data enqueue; accepted when not full or when popping
//   pop             dequeue the head; ignored when empty
//   head            current head entry (RESET_VAL straight out of reset)
//   empty, full     status flags
//   count           current occupancy
module fetch_fifo #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so full+pop+push is legal.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests to instruction memory,
// tags each with its PC, buffers returned words and presents {pc, inst}
// to decode. A redirect flushes the buffer and marks every outstanding
// request stale; stale responses are counted off and discarded.
//   clk, rst_n                     clock, async active-low reset
//   op_imem_req_valid/addr         fetch request to memory
//   ip_imem_req_ready              memory accepts the request
//   ip_imem_rsp_valid/data         in-order response, no backpressure
//   op_valid, op_inst, op_pc       entry presented to decode
//   ip_ready                       decode consumes the entry
//   ip_redirect, ip_redirect_pc    taken branch/jump target
module fetch_unit
  import eka_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            op_imem_req_valid,
  output logic [XLEN-1:0] op_imem_addr,
  input  logic            ip_imem_req_ready,
  input  logic            ip_imem_rsp_valid,
  input  logic [XLEN-1:0] ip_imem_rsp_data,
  output logic [XLEN-1:0] op_inst,
  output logic [XLEN-1:0] op_pc,
  output logic            op_valid,
  input  logic            ip_ready,
  input  logic            ip_redirect,
  input  logic [XLEN-1:0] ip_redirect_pc
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = $bits(fetch_entry_t);
  localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, inst: INST_NOP};

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             req_xfer;
  logic             rsp_ok;
  logic             rsp_stale;
  logic             rsp_good;
  logic             out_pop;
  logic [SUM_W-1:0] occupancy;

  fetch_entry_t     buf_head;
  fetch_entry_t     buf_in;
  logic             buf_empty, buf_full;
  logic [CNT_W-1:0] buf_count;

  logic [XLEN-1:0]  tag_head;
  logic             tag_empty, tag_full;
  logic [CNT_W-1:0] tag_count;

  // Issue only when the response is guaranteed a buffer slot.
  assign occupancy         = SUM_W'(inflight_q) + SUM_W'(buf_count);
  assign op_imem_req_valid = rst_n && !ip_redirect && (occupancy < SUM_W'(BUF_DEPTH));
  assign op_imem_addr      = pc_q;
  assign req_xfer          = op_imem_req_valid && ip_imem_req_ready;

  // A response with nothing outstanding is ignored.
  assign rsp_ok    = ip_imem_rsp_valid && (inflight_q != '0);
  assign rsp_stale = ip_redirect || (drop_q != '0);
  assign rsp_good  = rsp_ok && !rsp_stale && !tag_empty;

  assign buf_in    = '{pc: tag_head, inst: ip_imem_rsp_data};
  assign op_valid  = !buf_empty;
  assign op_inst   = buf_head.inst;
  assign op_pc     = buf_head.pc;
  assign out_pop   = op_valid && ip_ready;

  // Next-state for PC, in-flight and stale-drop counters.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CNT_W'(req_xfer) - CNT_W'(rsp_ok);
    drop_d     = drop_q;
    if (ip_redirect) begin
      pc_d   = align_pc(ip_redirect_pc);
      // Everything still outstanding after this edge belongs to the old path.
      drop_d = inflight_d;
    end else begin
      if (req_xfer) pc_d = pc_q + XLEN'(4);
      if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // PC of each live request, in issue order.
  fetch_fifo #(
    .WIDTH     (XLEN),
    .DEPTH     (BUF_DEPTH),
    .RESET_VAL (RESET_PC),
    .CNT_W     (CNT_W)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (ip_redirect),
    .push      (req_xfer && !ip_redirect),
    .push_data (pc_q),
    .pop       (rsp_good),
    .head      (tag_head),
    .empty     (tag_empty),
    .full      (tag_full),
    .count     (tag_count)
  );

  // Instruction buffer feeding decode; head is the registered output.
  fetch_fifo #(
    .WIDTH     (ENT_W),
    .DEPTH     (BUF_DEPTH),
    .RESET_VAL (RESET_ENTRY),
    .CNT_W     (CNT_W)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (ip_redirect),
    .push      (rsp_good),
    .push_data (buf_in),
    .pop       (out_pop),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  // Protocol and internal consistency checks.
  a_rsp_with_request: assert property (@(posedge clk) disable iff (!rst_n)
    ip_imem_rsp_valid |-> (inflight_q != '0));
  a_buf_slot: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_good |-> (!buf_full || out_pop));
  a_tag_slot: assert property (@(posedge clk) disable iff (!rst_n)
    req_xfer |-> !tag_full);
  a_tag_count: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count <= inflight_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stalls and
// redirects, checked against a program-order stream model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 3;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_imem_req_valid;
  logic [31:0] op_imem_addr;
  logic        ip_imem_req_ready;
  logic        ip_imem_rsp_valid;
  logic [31:0] ip_imem_rsp_data;
  logic [31:0] op_inst;
  logic [31:0] op_pc;
  logic        op_valid;
  logic        ip_ready;
  logic        ip_redirect;
  logic [31:0] ip_redirect_pc;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .op_imem_req_valid (op_imem_req_valid),
    .op_imem_addr      (op_imem_addr),
    .ip_imem_req_ready (ip_imem_req_ready),
    .ip_imem_rsp_valid (ip_imem_rsp_valid),
    .ip_imem_rsp_data  (ip_imem_rsp_data),
    .op_inst           (op_inst),
    .op_pc             (op_pc),
    .op_valid          (op_valid),
    .ip_ready          (ip_ready),
    .ip_redirect       (ip_redirect),
    .ip_redirect_pc    (ip_redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Memory model: outstanding requests and the cycle each may return.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          mem_rdy_pct, dec_rdy_pct, lat_fixed, lat_max;

  // Program-order model: next PC decode must see, next PC memory must see.
  logic [31:0] exp_pc, exp_req;
  logic [31:0] deliv_q[$];
  bit          expect_empty;
  bit          prev_req_stall, prev_out_stall;
  logic [31:0] prev_addr, prev_pc, prev_inst;
  bit          last_valid, last_req_valid;
  logic [31:0] last_pc;
  int          xfers, delivered;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    ip_imem_req_ready = 1'b0;
    ip_imem_rsp_valid = 1'b0;
    ip_imem_rsp_data  = '0;
    ip_ready          = 1'b0;
    ip_redirect       = 1'b0;
    ip_redirect_pc    = '0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_req_valid", 32'(op_imem_req_valid), 32'd0);
    check("rst_op_pc", op_pc, RPC);
    check("rst_op_inst", op_inst, NOP);
    check("rst_addr", op_imem_addr, RPC);
    @(negedge clk);
    @(negedge clk);
    rst_n          = 1'b1;
    exp_pc         = RPC;
    exp_req        = RPC;
    expect_empty   = 1'b0;
    prev_req_stall = 1'b0;
    prev_out_stall = 1'b0;
    xfers          = 0;
    deliv_q.delete();
  endtask

  // One cycle: drive inputs, sample outputs, update models, cross one edge.
  task automatic step(input bit redir, input logic [31:0] tgt);
    ip_imem_rsp_valid = 1'b0;
    ip_imem_rsp_data  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      ip_imem_rsp_valid = 1'b1;
      ip_imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    ip_imem_req_ready = (int'($urandom_range(99)) < mem_rdy_pct);
    ip_ready          = (int'($urandom_range(99)) < dec_rdy_pct);
    ip_redirect       = redir;
    ip_redirect_pc    = tgt;
    #1;
    if (prev_req_stall && !redir) begin
      check("req_hold_valid", 32'(op_imem_req_valid), 32'd1);
      check("req_hold_addr", op_imem_addr, prev_addr);
    end
    if (prev_out_stall) begin
      check("out_hold_valid", 32'(op_valid), 32'd1);
      check("out_hold_pc", op_pc, prev_pc);
      check("out_hold_inst", op_inst, prev_inst);
    end
    if (expect_empty) check("redirect_empty", 32'(op_valid), 32'd0);
    last_valid     = op_valid;
    last_pc        = op_pc;
    last_req_valid = op_imem_req_valid;
    if (op_valid && ip_ready) begin
      check("deliv_pc", op_pc, exp_pc);
      check("deliv_inst", op_inst, mem_word(exp_pc));
      deliv_q.push_back(op_pc);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (op_imem_req_valid && ip_imem_req_ready) begin
      check("req_addr", op_imem_addr, exp_req);
      pend_addr.push_back(op_imem_addr);
      pend_due.push_back(cyc + 1 + lat_fixed + int'($urandom_range(lat_max)));
      exp_req = exp_req + 32'd4;
      xfers++;
    end
    if (redir) begin
      exp_pc  = tgt & ~32'd3;
      exp_req = tgt & ~32'd3;
    end
    prev_req_stall = op_imem_req_valid && !ip_imem_req_ready && !redir;
    prev_out_stall = op_valid && !ip_ready && !redir;
    prev_addr      = op_imem_addr;
    prev_pc        = op_pc;
    prev_inst      = op_inst;
    expect_empty   = redir;
    @(negedge clk);
    cyc++;
  endtask

  // Run until decode receives something new, bounded.
  task automatic run_until_delivery(input string tag, input logic [31:0] want);
    int start;
    bit got;
    start = deliv_q.size();
    got   = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(1'b0, '0);
      got = (deliv_q.size() > start);
    end
    if (got) check(tag, deliv_q[start], want);
    else     check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    delivered   = 0;
    mem_rdy_pct = 100;
    dec_rdy_pct = 100;
    lat_fixed   = 0;
    lat_max     = 0;
    @(negedge clk);
    do_reset();

    // Full-rate stream after a two-cycle fill (1-cycle memory, all ready).
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0);
      if (k < 2) begin
        check("fill_valid_low", 32'(last_valid), 32'd0);
      end else begin
        check("fill_valid", 32'(last_valid), 32'd1);
        check("fill_pc", last_pc, 32'(4 * (k - 2)));
      end
    end

    // Decode stalled: exactly DEPTH requests, then request valid drops.
    do_reset();
    dec_rdy_pct = 0;
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    check("stall_xfers", 32'(xfers), 32'(DEPTH));
    check("stall_req_low", 32'(last_req_valid), 32'd0);
    check("stall_head_pc", last_pc, RPC);
    dec_rdy_pct = 100;
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    check("stall_release_cnt", 32'(deliv_q.size()), 32'd10);

    // Redirect with two requests in flight: both responses dropped.
    do_reset();
    lat_fixed = 4;
    step(1'b0, '0);
    step(1'b0, '0);
    lat_fixed = 0;
    step(1'b1, 32'h0000_1003);
    run_until_delivery("redir_first_pc", 32'h0000_1000);

    // Redirect coinciding with a response arrival.
    do_reset();
    dec_rdy_pct = 0;
    step(1'b0, '0);
    step(1'b0, '0);
    dec_rdy_pct = 100;
    step(1'b1, 32'h0000_2000);
    run_until_delivery("redir_rsp_pc", 32'h0000_2000);

    // Redirect near the top of the address space: PC wraps to zero.
    do_reset();
    step(1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    if (deliv_q.size() >= 3) begin
      check("wrap_pc0", deliv_q[0], 32'hFFFF_FFF8);
      check("wrap_pc1", deliv_q[1], 32'hFFFF_FFFC);
      check("wrap_pc2", deliv_q[2], 32'h0000_0000);
    end else begin
      check("wrap_count", 32'(deliv_q.size()), 32'd3);
    end

    // Randomized stalls, latencies and redirects, with a mid-run reset.
    do_reset();
    mem_rdy_pct = 70;
    dec_rdy_pct = 70;
    lat_max     = 3;
    delivered   = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      if ($urandom_range(99) < 4) step(1'b1, $urandom);
      else                        step(1'b0, '0);
    end
    mem_rdy_pct = 100;
    dec_rdy_pct = 100;
    lat_max     = 0;
    for (int k = 0; k < 20; k++) step(1'b0, '0);
    check("random_progress", 32'(delivered > 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
